// File: rtl/wdt_timeout_core.sv
// -----------------------------------------------------------------------------
// wdt_timeout_core
//
// Watchdog counting engine running entirely in the watchdog clock domain (clk2).
// It consumes the already-synchronized enable (WDEN), kick level (WDLIVE) and
// timeout limit (WTOCNT) from the register/CDC wrapper. It counts while enabled,
// restarts on every rising edge of the kick level, and raises a sticky timeout
// flag once the count reaches the programmed limit. The wrapper resynchronizes
// wto_o back into the system clock domain.
//
// Optional feature macro: WDT_PRESCALE_EN
//   When defined, the counter advances (and the limit compare is evaluated)
//   only once every PRESCALE clocks. When undefined, no prescaler exists and
//   the counter ticks on every clock.
// -----------------------------------------------------------------------------
module wdt_timeout_core #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned PRESCALE = 16
) (
    input  logic             clk2,
    input  logic             rst2_n,
    input  logic             wden_i,
    input  logic             wdlive_i,
    input  logic [CNT_W-1:0] wtocnt_i,
    input  logic             wtocnt_vld_i,
    output logic             wto_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [1:0]       state_o
);

    // Encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] limit_q;
    logic [CNT_W-1:0] limit_d;
    logic             wto_q;
    logic             wto_d;
    logic             wdlive_q;

    logic             kick;
    logic             tick;
    logic             limit_hit;

    // A kick is the rising edge of the synchronized live level; holding the
    // level high therefore counts as exactly one kick.
    assign kick = wdlive_i & ~wdlive_q;

    // The compare uses the registered limit, so a freshly written limit only
    // takes part in the decision from the edge after it was loaded. Using >=
    // rather than == means a limit lowered below the current count still
    // fires on the next compare instead of letting the counter run on.
    assign limit_hit = (cnt_q >= limit_q);

`ifdef WDT_PRESCALE_EN
    // Prescaler width covers 0..PRESCALE-1; a PRESCALE of 1 still needs one bit.
    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    // The counter only advances on the last prescaler phase.
    assign tick = (pre_q == PRE_LAST);

    // Prescaler only runs while counting; any restart (enable drop, kick,
    // entering COUNT, or a completed tick) brings it back to phase 0.
    always_comb begin
        pre_d = '0;
        if ((state_q == ST_COUNT) && wden_i && !kick && !tick) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Prescaler phase register.
    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    // Without the prescaler every clock is a counter tick.
    assign tick = 1'b1;
`endif

    // The limit register accepts a new value whenever the CDC presents one,
    // independent of the FSM state.
    always_comb begin
        limit_d = limit_q;
        if (wtocnt_vld_i) begin
            limit_d = wtocnt_i;
        end
    end

    // Next-state and next-output logic. Priority inside one edge is:
    // enable dropped, then kick, then the limit compare.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wto_d   = wto_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                wto_d = 1'b0;
                if (wden_i) begin
                    state_d = ST_COUNT;
                end
            end

            ST_COUNT: begin
                if (!wden_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (kick) begin
                    cnt_d = '0;
                end else if (tick) begin
                    if (limit_hit) begin
                        state_d = ST_TIMEOUT;
                        wto_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_TIMEOUT: begin
                if (!wden_i) begin
                    state_d = ST_IDLE;
                    wto_d   = 1'b0;
                    cnt_d   = '0;
                end else if (kick) begin
                    state_d = ST_COUNT;
                    wto_d   = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                wto_d   = 1'b0;
            end
        endcase
    end

    // State, count, flag, limit and kick-edge registers. Reset is asynchronous
    // so a reset asserted mid-operation clears outputs without a clock edge.
    always_ff @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wto_q    <= 1'b0;
            limit_q  <= '0;
            wdlive_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wto_q    <= wto_d;
            limit_q  <= limit_d;
            wdlive_q <= wdlive_i;
        end
    end

    // All outputs come straight from registers, so they cannot glitch.
    assign wto_o   = wto_q;
    assign cnt_o   = cnt_q;
    assign state_o = state_q;

    // A prescaler of zero would never tick; reject that configuration.
    always_comb begin
        assert (PRESCALE >= 1);
    end

    // The sticky flag is high exactly while the FSM sits in TIMEOUT.
    assert property (@(posedge clk2) disable iff (!rst2_n)
                     wto_q == (state_q == ST_TIMEOUT));

endmodule

// File: tb/tb_wdt_timeout_core.sv
// -----------------------------------------------------------------------------
// tb_wdt_timeout_core
//
// Self-checking bench for wdt_timeout_core. A behavioural model of the
// watchdog (plain integers, rule-by-rule) is compared with the DUT on every
// falling clock edge; directed sequences add hand-computed literal checks that
// pin the model, followed by a randomized phase. Honors WDT_PRESCALE_EN with a
// prescale of 4.
// -----------------------------------------------------------------------------
module tb_wdt_timeout_core;

    localparam int CNT_W       = 32;
    localparam int TB_PRESCALE = 4;

    localparam int M_IDLE    = 0;
    localparam int M_COUNT   = 1;
    localparam int M_TIMEOUT = 2;

    logic             clk2         = 1'b0;
    logic             rst2_n       = 1'b0;
    logic             wden_i       = 1'b0;
    logic             wdlive_i     = 1'b0;
    logic [CNT_W-1:0] wtocnt_i     = '0;
    logic             wtocnt_vld_i = 1'b0;
    logic             wto_o;
    logic [CNT_W-1:0] cnt_o;
    logic [1:0]       state_o;

    int nCompared   = 0;
    int nMismatched = 0;
    bit cmpEn       = 1'b0;

    // Behavioural model state.
    int              mState = M_IDLE;
    longint unsigned mCnt   = 0;
    longint unsigned mLimit = 0;
    longint unsigned mLim   = 0;
    bit              mWto   = 1'b0;
    bit              mLiveQ = 1'b0;
    bit              mKick  = 1'b0;
    bit              mTick  = 1'b0;
    int              mPresc = 0;

    // Random phase variables.
    logic             rEn;
    logic             rLive = 1'b0;
    logic             rVld;
    logic [CNT_W-1:0] rLim;

    // Free-running watchdog clock.
    always #5 clk2 = ~clk2;

    wdt_timeout_core #(
        .CNT_W    (CNT_W),
        .PRESCALE (TB_PRESCALE)
    ) dut (
        .clk2         (clk2),
        .rst2_n       (rst2_n),
        .wden_i       (wden_i),
        .wdlive_i     (wdlive_i),
        .wtocnt_i     (wtocnt_i),
        .wtocnt_vld_i (wtocnt_vld_i),
        .wto_o        (wto_o),
        .cnt_o        (cnt_o),
        .state_o      (state_o)
    );

    // Drive all inputs at once; callers invoke this just after a rising edge.
    task automatic applyStimulus(input logic en, input logic live,
                                 input logic [CNT_W-1:0] lim, input logic vld);
        wden_i       = en;
        wdlive_i     = live;
        wtocnt_i     = lim;
        wtocnt_vld_i = vld;
    endtask

    // One comparison; four-state compare so X/Z on the DUT is a failure.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    // Bounded wait until the count shows a target value.
    task automatic waitCnt(input string name, input logic [CNT_W-1:0] target);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            step();
            if (cnt_o == target) seen = 1'b1;
        end
        if (!seen) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: count never reached %0d", name, target);
        end
    endtask

    // Bounded wait until the timeout flag rises.
    task automatic waitWto(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            step();
            if (wto_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL %s: timeout flag never rose", name);
        end
    endtask

    // Return to IDLE with the kick level low.
    task automatic goIdle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        step();
        step();
    endtask

    // Load a limit, enable, and count edges (first enabled edge = 1) until
    // the flag rises; the count at timeout must equal the limit.
    task automatic runTimeout(input string name, input logic [CNT_W-1:0] lim,
                              input int expEdge);
        int edgeN;
        edgeN = 0;
        applyStimulus(1'b0, 1'b0, lim, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        for (int n = 1; n <= 2000 && edgeN == 0; n++) begin
            step();
            if (wto_o === 1'b1) edgeN = n;
        end
        checkOutput({name, "_edge"}, edgeN, expEdge);
        checkOutput({name, "_cnt"}, cnt_o, lim);
        checkOutput({name, "_state"}, state_o, 2);
    endtask

    // Reference model: applies the watchdog rules on each rising edge using
    // the limit that was in force before this edge.
    always @(posedge clk2 or negedge rst2_n) begin
        if (!rst2_n) begin
            mState = M_IDLE;
            mCnt   = 0;
            mLimit = 0;
            mWto   = 1'b0;
            mLiveQ = 1'b0;
            mPresc = 0;
        end else begin
            mKick = wdlive_i && !mLiveQ;
            mLim  = mLimit;
`ifdef WDT_PRESCALE_EN
            mTick = (mPresc == TB_PRESCALE - 1);
`else
            mTick = 1'b1;
`endif
            if (!wden_i) begin
                mState = M_IDLE;
                mCnt   = 0;
                mWto   = 1'b0;
                mPresc = 0;
            end else if (mState == M_IDLE) begin
                mState = M_COUNT;
                mCnt   = 0;
                mPresc = 0;
            end else if (mKick) begin
                mState = M_COUNT;
                mCnt   = 0;
                mWto   = 1'b0;
                mPresc = 0;
            end else if (mState == M_COUNT) begin
                if (mTick) begin
                    mPresc = 0;
                    if (mCnt >= mLim) begin
                        mState = M_TIMEOUT;
                        mWto   = 1'b1;
                    end else begin
                        mCnt = mCnt + 1;
                    end
                end else begin
                    mPresc = mPresc + 1;
                end
            end
            mLiveQ = wdlive_i;
            if (wtocnt_vld_i) mLimit = wtocnt_i;
        end
    end

    // Every-cycle compare of the DUT against the model, away from the active edge.
    always @(negedge clk2) begin
        if (cmpEn) begin
            checkOutput("cyc_state", state_o, mState);
            checkOutput("cyc_cnt", cnt_o, mCnt);
            checkOutput("cyc_wto", wto_o, mWto);
        end
    end

    // Hard stop in case something wedges the stimulus.
    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global time limit exceeded");
    end

    // Directed sequences, then randomized traffic, then the summary.
    initial begin
        rst2_n = 1'b0;
        repeat (3) @(posedge clk2);
        #3;
        rst2_n = 1'b1;
        cmpEn  = 1'b1;
        $display("[TB] reset released");

        checkOutput("rst_wto", wto_o, 0);
        checkOutput("rst_cnt", cnt_o, 0);
        checkOutput("rst_state", state_o, 0);
        repeat (20) step();
        checkOutput("idle20_wto", wto_o, 0);
        checkOutput("idle20_cnt", cnt_o, 0);
        checkOutput("idle20_state", state_o, 0);

        $display("[TB] basic timeout");
`ifdef WDT_PRESCALE_EN
        runTimeout("basic", 2, 13);
`else
        runTimeout("basic", 5, 7);
`endif
        repeat (10) step();
        checkOutput("basic_sticky_wto", wto_o, 1);
        checkOutput("basic_sticky_state", state_o, 2);
`ifdef WDT_PRESCALE_EN
        checkOutput("basic_sticky_cnt", cnt_o, 2);
`else
        checkOutput("basic_sticky_cnt", cnt_o, 5);
`endif
        goIdle();

        $display("[TB] kick restart");
        applyStimulus(1'b0, 1'b0, 10, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        waitCnt("kick_reach7", 7);
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        step();
        checkOutput("kick_cnt", cnt_o, 0);
        checkOutput("kick_state", state_o, 1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        waitWto("kick_reach_to");
        applyStimulus(1'b1, 1'b1, '0, 1'b0);
        step();
        checkOutput("kickto_wto", wto_o, 0);
        checkOutput("kickto_state", state_o, 1);
        checkOutput("kickto_cnt", cnt_o, 0);
        goIdle();

        $display("[TB] disable beats kick");
        applyStimulus(1'b0, 1'b0, 10, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        waitCnt("prio_reach10", 10);
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        step();
        checkOutput("prio_state", state_o, 0);
        checkOutput("prio_wto", wto_o, 0);
        checkOutput("prio_cnt", cnt_o, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        repeat (15) step();
        checkOutput("prio_no_to", wto_o, 0);

        $display("[TB] limit lowered while counting");
        applyStimulus(1'b0, 1'b0, 100, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        waitCnt("lim_reach39", 39);
        applyStimulus(1'b1, 1'b0, 20, 1'b1);
        step();
`ifndef WDT_PRESCALE_EN
        checkOutput("lim_cnt40", cnt_o, 40);
        checkOutput("lim_wto_low", wto_o, 0);
`endif
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        step();
`ifndef WDT_PRESCALE_EN
        checkOutput("lim_wto_high", wto_o, 1);
        checkOutput("lim_cnt_hold", cnt_o, 40);
`endif
        repeat (10) step();
        goIdle();
`ifdef WDT_PRESCALE_EN
        runTimeout("lim0", 0, 5);
`else
        runTimeout("lim0", 0, 2);
`endif
        goIdle();

        $display("[TB] asynchronous reset");
        applyStimulus(1'b0, 1'b0, 50, 1'b1);
        step();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        waitCnt("ar_reach33", 33);
        #2;
        rst2_n = 1'b0;
        #1;
        checkOutput("ar_count_cnt", cnt_o, 0);
        checkOutput("ar_count_wto", wto_o, 0);
        checkOutput("ar_count_state", state_o, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk2);
        #3;
        rst2_n = 1'b1;
        step();
`ifdef WDT_PRESCALE_EN
        runTimeout("ar_to", 3, 17);
`else
        runTimeout("ar_to", 3, 5);
`endif
        #2;
        rst2_n = 1'b0;
        #1;
        checkOutput("ar_to_cnt", cnt_o, 0);
        checkOutput("ar_to_wto", wto_o, 0);
        checkOutput("ar_to_state", state_o, 0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(posedge clk2);
        #3;
        rst2_n = 1'b1;
        step();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            rEn  = ($urandom_range(0, 99) < 93);
            if ($urandom_range(0, 99) < 12) rLive = ~rLive;
            rVld = ($urandom_range(0, 99) < 4);
            rLim = ($urandom_range(0, 99) < 2) ? 32'hFFFF_FFFF : CNT_W'($urandom_range(0, 30));
            applyStimulus(rEn, rLive, rLim, rVld);
            step();
        end
        goIdle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
